// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and types for the MEM->WB stage.
// Also hosts the skid-buffer state encoding.
package mem_wb_pipe_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // bit0 = main slot valid, bit1 = skid slot valid
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

  function automatic int payload_w(
    input int reg_w,
    input int addr_w,
    input int hilo_en
  );
    int w;
    w = addr_w + 1 + reg_w;
    if (hilo_en != 0) w = w + 1 + 2 * reg_w;
    return w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// Registered in_ready, sync clear, empty slots read as zero.
module pipe_skid_buf
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q;
  skid_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              rdy_q;
  logic              accept;
  logic              consume;

  assign accept    = in_valid & rdy_q;
  assign consume   = state_q[0] & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = state_q[0];
  assign out_data  = main_q;

  // Next slot contents from the handshake outcome
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (consume) begin
          main_d  = '0;
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = SKID_ONE;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  // State/slot registers; reset beats clear beats handshake
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clr) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != SKID_FULL);
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with skid buffer.
// Pack payload, buffer it, unpack; HI/LO optional.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int REG_W      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int HILO_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [REG_W-1:0]      mem_wdata,
  input  logic                  mem_whilo,
  input  logic [REG_W-1:0]      mem_hi,
  input  logic [REG_W-1:0]      mem_lo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic                  wb_whilo,
  output logic [REG_W-1:0]      wb_hi,
  output logic [REG_W-1:0]      wb_lo
);

  localparam int PAY_W =
    payload_w(REG_W, REG_ADDR_W, HILO_EN);

  logic [PAY_W-1:0] din;
  logic [PAY_W-1:0] dout;

  pipe_skid_buf #(
    .DATA_W (PAY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (dout)
  );

  generate
    if (HILO_EN != 0) begin : g_hilo
      assign din = {mem_wd, mem_wreg, mem_wdata,
                    mem_whilo, mem_hi, mem_lo};
      assign {wb_wd, wb_wreg, wb_wdata,
              wb_whilo, wb_hi, wb_lo} = dout;
    end else begin : g_nohilo
      logic unused_hilo;
      assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
      assign din = {mem_wd, mem_wreg, mem_wdata};
      assign {wb_wd, wb_wreg, wb_wdata} = dout;
      assign wb_whilo = WRITE_DISABLE;
      assign wb_hi    = '0;
      assign wb_lo    = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed table, hand sequences,
// random traffic against a queue model (HILO on and off).
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo;

  logic        in_ready_a, out_valid_a;
  logic [4:0]  wb_wd_a;
  logic        wb_wreg_a, wb_whilo_a;
  logic [31:0] wb_wdata_a, wb_hi_a, wb_lo_a;

  logic        in_ready_b, out_valid_b;
  logic [4:0]  wb_wd_b;
  logic        wb_wreg_b, wb_whilo_b;
  logic [31:0] wb_wdata_b, wb_hi_b, wb_lo_b;

  always #5 clk = ~clk;

  mem_wb_pipe #(.REG_W(32), .REG_ADDR_W(5), .HILO_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .wb_wd(wb_wd_a), .wb_wreg(wb_wreg_a), .wb_wdata(wb_wdata_a),
    .wb_whilo(wb_whilo_a), .wb_hi(wb_hi_a), .wb_lo(wb_lo_a)
  );

  mem_wb_pipe #(.REG_W(32), .REG_ADDR_W(5), .HILO_EN(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .wb_wd(wb_wd_b), .wb_wreg(wb_wreg_b), .wb_wdata(wb_wdata_b),
    .wb_whilo(wb_whilo_b), .wb_hi(wb_hi_b), .wb_lo(wb_lo_b)
  );

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } bundle_t;

  typedef struct {
    logic       iv;
    logic [4:0] wd;
    logic       ordy;
    logic       fl;
    logic       e_ov;
    logic [4:0] e_wd;
    logic       e_rdy;
  } row_t;

  bundle_t      q[$];
  row_t         tbl[$];
  bit           model_on = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [104:0] s_a, s_b;

  // Model view: a FIFO of at most two bundles; ready while < 2 held
  function automatic logic [104:0] exp_vec(input bit hilo);
    bundle_t f;
    logic    ov, rdy;
    f   = '0;
    ov  = (q.size() > 0);
    rdy = (q.size() < 2);
    if (ov) f = q[0];
    if (!hilo) begin
      f.whilo = 1'b0;
      f.hi    = '0;
      f.lo    = '0;
    end
    return {ov, rdy, f.wd, f.wreg, f.wdata, f.whilo, f.hi, f.lo};
  endfunction

  task automatic check(input string name,
                       input logic [104:0] act,
                       input logic [104:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bundle_t cur;
    bit acc, con;
    cur = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo};
    if (rst || flush) begin
      q.delete();
      model_on = 1;
    end else if (model_on) begin
      acc = in_valid && (q.size() < 2);
      con = out_ready && (q.size() > 0);
      if (con) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_a = {out_valid_a, in_ready_a, wb_wd_a, wb_wreg_a,
           wb_wdata_a, wb_whilo_a, wb_hi_a, wb_lo_a};
    s_b = {out_valid_b, in_ready_b, wb_wd_b, wb_wreg_b,
           wb_wdata_b, wb_whilo_b, wb_hi_b, wb_lo_b};
    if (model_on) begin
      check("model_hilo", s_a, exp_vec(1'b1));
      check("model_nohilo", s_b, exp_vec(1'b0));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi,
                       input logic [31:0] lo);
    in_valid  = iv;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_whilo = whilo;
    mem_hi    = hi;
    mem_lo    = lo;
  endtask

  task automatic add(input int iv, input int wd, input int ordy,
                     input int fl, input int ov, input int ewd,
                     input int rdy);
    row_t r;
    r.iv    = 1'(iv);
    r.wd    = 5'(wd);
    r.ordy  = 1'(ordy);
    r.fl    = 1'(fl);
    r.e_ov  = 1'(ov);
    r.e_wd  = 5'(ewd);
    r.e_rdy = 1'(rdy);
    tbl.push_back(r);
  endtask

  initial begin
    logic [31:0] wdat;
    logic [104:0] ev;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'h5, 1'b1, 32'h1, 32'h2);
    #1;

    // reset held two cycles with in_valid high
    cycle();
    cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("reset_ov", {104'b0, s_a[104]}, 105'd0);
    check("reset_wreg", {104'b0, s_a[97]}, 105'd0);
    check("reset_wd", {100'b0, s_a[102:98]}, 105'd0);
    check("reset_rdy", {104'b0, s_a[103]}, 105'd1);

    // streaming
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 2, 1, 0, 1, 1, 1);
    add(1, 3, 1, 0, 1, 2, 1);
    add(1, 4, 1, 0, 1, 3, 1);
    add(0, 0, 1, 0, 1, 4, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    // back-pressure
    add(1, 5, 0, 0, 0, 0, 1);
    add(1, 6, 0, 0, 1, 5, 1);
    add(1, 8, 0, 0, 1, 5, 0);
    add(1, 8, 1, 0, 1, 5, 0);
    add(1, 8, 1, 0, 1, 6, 1);
    add(0, 0, 1, 0, 1, 8, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    // flush while full
    add(1, 9, 0, 0, 0, 0, 1);
    add(1, 10, 0, 0, 1, 9, 1);
    add(1, 7, 0, 1, 1, 9, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      wdat = 32'(tbl[i].wd) * 32'h11;
      drive(tbl[i].iv, tbl[i].wd, 1'b1, wdat, 1'b0, 32'h0, 32'h0);
      out_ready = tbl[i].ordy;
      flush = tbl[i].fl;
      cycle();
      ev = '0;
      ev[104] = tbl[i].e_ov;
      ev[103] = tbl[i].e_rdy;
      ev[102:98] = tbl[i].e_wd;
      ev[97] = tbl[i].e_ov;
      ev[96:65] = 32'(tbl[i].e_wd) * 32'h11;
      check($sformatf("table_row%0d", i), s_a, ev);
    end
    flush = 1'b0;

    // HI/LO bundle through both variants
    out_ready = 1'b1;
    drive(1'b1, 5'd2, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h12345678);
    cycle();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("hilo_on", {40'b0, s_a[64:0]},
          {40'b0, 1'b1, 32'hDEADBEEF, 32'h12345678});
    check("hilo_off", {40'b0, s_b[64:0]}, 105'd0);

    // bubble passes through
    drive(1'b1, 5'd4, 1'b0, 32'h9, 1'b0, 32'h0, 32'h0);
    cycle();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("bubble", {102'b0, s_a[104], s_a[97], s_a[64]},
          {102'b0, 3'b100});

    // reset while full
    out_ready = 1'b0;
    drive(1'b1, 5'd11, 1'b1, 32'hA, 1'b1, 32'h3, 32'h4);
    cycle();
    drive(1'b1, 5'd12, 1'b1, 32'hB, 1'b0, 32'h0, 32'h0);
    cycle();
    drive(1'b1, 5'd13, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    cycle();
    check("full_before_rst", {103'b0, s_a[104:103]},
          {103'b0, 2'b10});
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("midop_reset", s_a, {1'b0, 1'b1, 103'b0});

    // random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
